// File: rtl/mips_pkg.sv
// Shared constants and source-id encoding for the writeback path.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // Identity of a writeback source; also the encoding of last_grant.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request channels, the register file write
// port, the decode hazard query and the grant counter.
interface regfile_write_arbiter_if
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);
  logic          stall;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_reg;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_reg;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          regWrite;
  logic [AW-1:0] query_reg_1;
  logic [AW-1:0] query_reg_2;
  logic          hazard_1;
  logic          hazard_2;
  logic [15:0]   grant_cnt;

  // Requesters, decode and the register file drive/observe the arbiter.
  modport master (
    output stall, alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
           query_reg_1, query_reg_2,
    input  alu_ready, mem_ready, write_reg, write_data, regWrite,
           hazard_1, hazard_2, grant_cnt
  );

  // The arbiter itself.
  modport slave (
    input  stall, alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
           query_reg_1, query_reg_2,
    output alu_ready, mem_ready, write_reg, write_data, regWrite,
           hazard_1, hazard_2, grant_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-request grant: round-robin on ties, or memory-first when FIXED_PRIO=1.
module rr_arbiter2
  import mips_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  src_t last_grant;

  // Grant decision; reset and stall both suppress every grant.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (!(rst || stall)) begin
      if (req_alu && req_mem) begin
        if ((FIXED_PRIO != 0) || (last_grant == SRC_ALU)) gnt_mem = 1'b1;
        else                                              gnt_alu = 1'b1;
      end else begin
        gnt_alu = req_alu;
        gnt_mem = req_mem;
      end
    end
  end

  // Remember who won the last accepted transfer; reset favours the ALU next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_grant <= SRC_MEM;
    else if (gnt_alu) last_grant <= SRC_ALU;
    else if (gnt_mem) last_grant <= SRC_MEM;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU and load writeback
// paths, registers the winning write and flags read-after-write hazards.
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int ADDR_W     = mips_pkg::ADDR_W,
  parameter int FIXED_PRIO = 0
) (
  input logic                     clk,
  input logic                     rst,
  regfile_write_arbiter_if.slave  bus
);

  logic              gnt_alu;
  logic              gnt_mem;
  logic              accept;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              reg_write_q;
  logic [15:0]       grant_cnt_q;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .stall   (bus.stall),
    .req_alu (bus.alu_valid),
    .req_mem (bus.mem_valid),
    .gnt_alu (gnt_alu),
    .gnt_mem (gnt_mem)
  );

  assign bus.alu_ready = gnt_alu;
  assign bus.mem_ready = gnt_mem;

  // Mux the winning source's destination and data.
  always_comb begin
    accept   = gnt_alu | gnt_mem;
    sel_reg  = gnt_mem ? bus.mem_reg  : bus.alu_reg;
    sel_data = gnt_mem ? bus.mem_data : bus.alu_data;
  end

  // Output register: one regWrite pulse per accepted non-$0 write; the index
  // and data hold their last real write otherwise. $0 writes still count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_cnt_q  <= '0;
    end else begin
      reg_write_q <= accept && (sel_reg != ZERO_REG);
      if (accept && (sel_reg != ZERO_REG)) begin
        write_reg_q  <= sel_reg;
        write_data_q <= sel_data;
      end
      if (accept) grant_cnt_q <= grant_cnt_q + 16'd1;
    end
  end

  assign bus.regWrite   = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.grant_cnt  = grant_cnt_q;

  // Hazard: a nonzero query index matches a pending request or the write in flight.
  always_comb begin
    bus.hazard_1 = (bus.query_reg_1 != ZERO_REG) &&
                   ((reg_write_q   && (write_reg_q == bus.query_reg_1)) ||
                    (bus.alu_valid && (bus.alu_reg == bus.query_reg_1)) ||
                    (bus.mem_valid && (bus.mem_reg == bus.query_reg_1)));
    bus.hazard_2 = (bus.query_reg_2 != ZERO_REG) &&
                   ((reg_write_q   && (write_reg_q == bus.query_reg_2)) ||
                    (bus.alu_valid && (bus.alu_reg == bus.query_reg_2)) ||
                    (bus.mem_valid && (bus.mem_reg == bus.query_reg_2)));
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a round-robin instance and a
// fixed-priority instance sharing clock and reset.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if if0 ();
  regfile_write_arbiter_if if1 ();

  regfile_write_arbiter #(.FIXED_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  regfile_write_arbiter #(.FIXED_PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.stall = 0; if0.alu_valid = 0; if0.alu_reg = 0; if0.alu_data = 0;
    if0.mem_valid = 0; if0.mem_reg = 0; if0.mem_data = 0;
    if0.query_reg_1 = 0; if0.query_reg_2 = 0;
    if1.stall = 0; if1.alu_valid = 0; if1.alu_reg = 0; if1.alu_data = 0;
    if1.mem_valid = 0; if1.mem_reg = 0; if1.mem_data = 0;
    if1.query_reg_1 = 0; if1.query_reg_2 = 0;
  endtask

  task automatic set_both(input logic v);
    if0.alu_valid = v; if0.alu_reg = 5'd3; if0.alu_data = 32'd10;
    if0.mem_valid = v; if0.mem_reg = 5'd4; if0.mem_data = 32'd20;
    if1.alu_valid = v; if1.alu_reg = 5'd3; if1.alu_data = 32'd10;
    if1.mem_valid = v; if1.mem_reg = 5'd4; if1.mem_data = 32'd20;
  endtask

  // Expected per-cycle results for the both-valid run (round-robin instance).
  logic       exp_alu_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [4:0] exp_wreg    [4] = '{5'd3, 5'd4, 5'd3, 5'd4};

  initial begin
    idle_inputs();

    // Reset state, with a request presented while reset is held.
    if0.alu_valid = 1; if0.alu_reg = 5'd5;
    tick(); tick();
    check("rst_alu_ready_forced0", 32'(if0.alu_ready), 0);
    check("rst_regWrite", 32'(if0.regWrite), 0);
    check("rst_write_reg", 32'(if0.write_reg), 0);
    check("rst_write_data", if0.write_data, 0);
    check("rst_grant_cnt", 32'(if0.grant_cnt), 0);
    if0.alu_valid = 0;
    rst = 0;
    tick();

    // 1: single ALU write.
    if0.alu_valid = 1; if0.alu_reg = 5'd5; if0.alu_data = 32'd55;
    #1;
    check("t1_alu_ready", 32'(if0.alu_ready), 1);
    check("t1_mem_ready", 32'(if0.mem_ready), 0);
    tick();
    if0.alu_valid = 0;
    #1;
    check("t1_regWrite", 32'(if0.regWrite), 1);
    check("t1_write_reg", 32'(if0.write_reg), 5);
    check("t1_write_data", if0.write_data, 55);
    check("t1_grant_cnt", 32'(if0.grant_cnt), 1);
    tick();
    check("t1_regWrite_drop", 32'(if0.regWrite), 0);
    check("t1_write_reg_hold", 32'(if0.write_reg), 5);

    // 2/3: both sources valid from reset, held throughout.
    rst = 1; tick(); rst = 0;
    set_both(1);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_alu_ready_c%0d", i), 32'(if0.alu_ready), 32'(exp_alu_rdy[i]));
      check($sformatf("t2_mem_ready_c%0d", i), 32'(if0.mem_ready), 32'(!exp_alu_rdy[i]));
      check($sformatf("t3_mem_ready_c%0d", i), 32'(if1.mem_ready), 1);
      check($sformatf("t3_alu_ready_c%0d", i), 32'(if1.alu_ready), 0);
      tick();
      check($sformatf("t2_write_reg_c%0d", i), 32'(if0.write_reg), 32'(exp_wreg[i]));
      check($sformatf("t2_regWrite_c%0d", i), 32'(if0.regWrite), 1);
      check($sformatf("t3_write_reg_c%0d", i), 32'(if1.write_reg), 4);
      if (i == 3) set_both(0);
    end
    check("t2_grant_cnt", 32'(if0.grant_cnt), 4);
    check("t3_grant_cnt", 32'(if1.grant_cnt), 4);
    tick();
    check("t2_regWrite_idle", 32'(if0.regWrite), 0);

    // 4: write to $0 is accepted but never reaches the register file.
    if0.mem_valid = 1; if0.mem_reg = 5'd0; if0.mem_data = 32'hDEAD;
    #1;
    check("t4_mem_ready", 32'(if0.mem_ready), 1);
    check("t4_hazard_q0", 32'(if0.hazard_1), 0);
    tick();
    if0.mem_valid = 0;
    #1;
    check("t4_regWrite", 32'(if0.regWrite), 0);
    check("t4_grant_cnt", 32'(if0.grant_cnt), 5);
    tick();

    // 5: stalled ALU request and hazard tracking.
    if0.alu_valid = 1; if0.alu_reg = 5'd7; if0.alu_data = 32'd77;
    if0.stall = 1; if0.query_reg_1 = 5'd7; if0.query_reg_2 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t5_stall_alu_ready_c%0d", i), 32'(if0.alu_ready), 0);
      check($sformatf("t5_stall_hazard_1_c%0d", i), 32'(if0.hazard_1), 1);
      check($sformatf("t5_stall_hazard_2_c%0d", i), 32'(if0.hazard_2), 0);
      tick();
    end
    if0.stall = 0;
    #1;
    check("t5_alu_ready", 32'(if0.alu_ready), 1);
    check("t5_hazard_1_pending", 32'(if0.hazard_1), 1);
    tick();
    if0.alu_valid = 0;
    #1;
    check("t5_regWrite", 32'(if0.regWrite), 1);
    check("t5_write_reg", 32'(if0.write_reg), 7);
    check("t5_hazard_1_inflight", 32'(if0.hazard_1), 1);
    check("t5_hazard_2", 32'(if0.hazard_2), 0);
    tick();
    check("t5_hazard_1_clear", 32'(if0.hazard_1), 0);
    check("t5_grant_cnt", 32'(if0.grant_cnt), 6);
    if0.query_reg_1 = 0;

    // 6: asynchronous reset clears the registered write before the next edge.
    if0.alu_valid = 1; if0.alu_reg = 5'd9; if0.alu_data = 32'd99;
    tick();
    if0.alu_valid = 0;
    #1;
    check("t6_regWrite_before", 32'(if0.regWrite), 1);
    rst = 1;
    #1;
    check("t6_regWrite_async", 32'(if0.regWrite), 0);
    check("t6_write_reg_async", 32'(if0.write_reg), 0);
    check("t6_grant_cnt_async", 32'(if0.grant_cnt), 0);
    tick();
    rst = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback sources: the ALU result path and the load (memory) return path.
- Arbitrates with valid/ready handshakes.
- Registers the winning write onto the register file's write_reg/write_data/regWrite inputs.
- Drops writes to $0.
- Reports read-after-write hazards, so decode can stall on a register whose write has not yet landed.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
FIXED_PRIO, 0, 0 = round-robin between sources; 1 = memory source always wins

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  when 1, no grants are issued this cycle
alu_valid  in  1  ALU source has a write pending
alu_ready  out  1  ALU write accepted this cycle (combinational)
alu_reg  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load source has a write pending
mem_ready  out  1  load write accepted this cycle (combinational)
mem_reg  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
write_reg  out  ADDR_W  to register file write index (registered)
write_data  out  DATA_W  to register file write data (registered)
regWrite  out  1  to register file write enable (registered, one-cycle pulse per write)
query_reg_1  in  ADDR_W  decode read index 1
query_reg_2  in  ADDR_W  decode read index 2
hazard_1  out  1  query_reg_1 has a write pending or in flight (combinational)
hazard_2  out  1  query_reg_2 has a write pending or in flight (combinational)
grant_cnt  out  16  total accepted writes, wraps modulo 2^16

Behaviour:
- Reset (async, rst=1) sets:
  - regWrite=0, write_reg=0, write_data=0
  - last_grant=MEM, so the ALU wins the first tie
  - grant_cnt=0
  - ready outputs follow their combinational rules during reset but are forced to 0.
- Grant rules (combinational, evaluated each cycle):
  - stall=1 or rst=1: both readys are 0.
  - Only one source valid: that source is granted.
  - Both valid, FIXED_PRIO=1: the memory source is granted.
  - Both valid, FIXED_PRIO=0: the source not in last_grant is granted.
  - At most one ready is 1 per cycle; ready never asserts without the matching valid.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - A source must hold valid, reg and data stable until it is accepted.
- Latency: an accepted write appears on write_reg/write_data with regWrite=1 in the cycle after acceptance. The register file commits it at the next edge, so the value is readable two edges after acceptance.
- Throughput: one write per cycle; back-to-back grants to the same source are allowed.
- No accepted write that cycle: regWrite returns to 0. write_reg and write_data hold their last values.
- $0 writes:
  - reg==0 is still accepted (ready asserted, grant_cnt increments, last_grant updates).
  - regWrite stays 0 for that transfer.
- last_grant updates only on an accepted transfer.
- grant_cnt increments by 1 per accepted transfer and wraps from 0xFFFF to 0.
- Hazards, for each query index q:
  - hazard = (q != 0) && ((regWrite && write_reg == q) || (alu_valid && alu_reg == q) || (mem_valid && mem_reg == q)).
- Both sources target the same register in consecutive cycles: writes reach the file in grant order, so the later grant wins.
- Reset asserted mid-transfer: any registered write is discarded immediately (regWrite=0); pending requesters must re-present after reset.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and ADDR_W constants
  - the source-id encoding SRC_ALU=0, SRC_MEM=1
  - the constant ZERO_REG=0
- One natural sub-module, rr_arbiter2: a 2-request round-robin/fixed-priority grant with its last_grant state.
- Hazard compare and output register stay in the top module.

Test Plan:
1. Reset, then alu_valid=1, alu_reg=5, alu_data=55 for one cycle:
   - alu_ready=1 that cycle.
   - Next cycle write_reg=5, write_data=55, regWrite=1; the cycle after, regWrite=0.
   - grant_cnt=1.
2. Both valid from reset (alu_reg=3, alu_data=10; mem_reg=4, mem_data=20), held after acceptance, FIXED_PRIO=0:
   - Grants go ALU, MEM, ALU, MEM on successive cycles.
   - write_reg sequence is 3, 4, 3, 4, lagging by one cycle.
3. Same stimulus with FIXED_PRIO=1: mem_ready=1 every cycle, alu_ready=0, write_reg stays 4.
4. mem_valid=1, mem_reg=0, mem_data=0xDEAD:
   - mem_ready=1 and grant_cnt increments.
   - regWrite stays 0.
5. alu_valid=1 with alu_reg=7 and stall=1 for 3 cycles, query_reg_1=7:
   - alu_ready=0 and hazard_1=1 throughout.
   - After stall drops: accept, hazard_1 stays 1 during the regWrite cycle, then 0.
   - query_reg_2=0 gives hazard_2=0 throughout.
6. Assert rst asynchronously mid-cycle while regWrite=1: regWrite, write_reg and grant_cnt go to 0 immediately, before the next clock edge.
